// File: rtl/tri_word_deserializer_pkg.sv
// Shared types and helpers for the three-word lane deserializer.
package tri_deser_pkg;

  localparam int NUM_WORDS = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_t;

  function automatic int calc_beats(input int dw, input int lw);
    return (dw + 1) / lw;
  endfunction

endpackage

// File: rtl/tri_word_deserializer_if.sv
// Lane-side and frame-side handshake bundle for tri_word_deserializer.
// slave = deserializer view, master = link/consumer view.
interface tri_word_deserializer_if #(
  parameter int DW = 15,
  parameter int LW = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [LW-1:0]     s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic signed [DW:0] m_a1a;
  logic signed [DW:0] m_a2a;
  logic signed [DW:0] m_a3a;
  logic              frame_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_a1a, m_a2a, m_a3a, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_a1a, m_a2a, m_a3a, frame_err
  );
endinterface

// File: rtl/tri_word_deserializer_out_reg.sv
// One-frame output holding register; o_busy flags a held frame the consumer
// is not taking this cycle, so the assembler must not overwrite it.
module tri_deser_out_reg #(
  parameter int FW = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [FW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [FW-1:0] o_data,
  output logic          o_busy
);
  logic          r_valid;
  logic [FW-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_busy  = r_valid && !i_ready;
endmodule

// File: rtl/tri_word_deserializer.sv
// Reassembles LSB-first lane beats into three signed words and hands them out
// in parallel. Define TRI_DESER_LAST_CHECK_EN to enable s_last framing checks.
//
//   state   | meaning
//   COLLECT | shifting beats into the assembly register
//   DISCARD | dropping beats until s_last after a frame overran
module tri_word_deserializer
  import tri_deser_pkg::*;
#(
  parameter int DW = 15,
  parameter int LW = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  tri_word_deserializer_if.slave bus
);
  localparam int BEATS = calc_beats(DW, LW);
  localparam int FW    = NUM_WORDS * (DW + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((DW + 1) % LW != 0) begin : g_bad_cfg
      $error("tri_word_deserializer: DW+1 must be a multiple of LW");
    end
  endgenerate

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic [1:0]    r_word, w_word_nxt;
  logic [FW-1:0] r_asm, w_asm_nxt, w_asm_shift, w_out;
  logic          w_final, w_busy, w_s_ready, w_accept, w_load, w_m_valid;
`ifdef TRI_DESER_LAST_CHECK_EN
  logic          r_frame_err, w_err_nxt;
`else
  logic          w_unused;
  assign w_unused = bus.s_last;
`endif

  assign w_final     = (r_beat == BW'(BEATS - 1)) && (r_word == 2'(NUM_WORDS - 1));
  assign w_s_ready   = rst_n && ((r_state == DISCARD) || !(w_final && w_busy));
  assign w_accept    = bus.s_valid && w_s_ready;
  assign w_asm_shift = {bus.s_data, r_asm[FW-1:LW]};

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_word_nxt  = r_word;
    w_asm_nxt   = r_asm;
    w_load      = 1'b0;
`ifdef TRI_DESER_LAST_CHECK_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_asm_nxt = w_asm_shift;
          if (w_final) begin
            w_beat_nxt = '0;
            w_word_nxt = '0;
`ifdef TRI_DESER_LAST_CHECK_EN
            if (bus.s_last) begin
              w_load = 1'b1;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = DISCARD;
            end
`else
            w_load = 1'b1;
`endif
          end
`ifdef TRI_DESER_LAST_CHECK_EN
          else if (bus.s_last) begin
            w_err_nxt  = 1'b1;
            w_beat_nxt = '0;
            w_word_nxt = '0;
          end
`endif
          else if (r_beat == BW'(BEATS - 1)) begin
            w_beat_nxt = '0;
            w_word_nxt = r_word + 2'd1;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end
`ifdef TRI_DESER_LAST_CHECK_EN
      DISCARD: begin
        if (w_accept && bus.s_last) begin
          w_state_nxt = COLLECT;
          w_beat_nxt  = '0;
          w_word_nxt  = '0;
        end
      end
`endif
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_beat  <= '0;
      r_word  <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_word  <= w_word_nxt;
      r_asm   <= w_asm_nxt;
    end
  end

`ifdef TRI_DESER_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= w_err_nxt;
  end
  assign bus.frame_err = r_frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif

  tri_deser_out_reg #(.FW(FW)) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_asm_shift),
    .i_ready (bus.m_ready),
    .o_valid (w_m_valid),
    .o_data  (w_out),
    .o_busy  (w_busy)
  );

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_a1a   = w_out[DW:0];
  assign bus.m_a2a   = w_out[2*DW+1:DW+1];
  assign bus.m_a3a   = w_out[3*DW+2:2*DW+2];
endmodule

// File: doc/tri_word_deserializer.md
# tri_word_deserializer

Receive-side counterpart of the three-word signed output stage: accepts a narrow lane stream carrying frames of three signed words (a1a, a2a, a3a), reassembles them, and presents all three in parallel with a valid/ready handshake. Sits between the link/lane interface and the signed datapath consumers. Provides framing checks on `s_last` and full-rate throughput with single-frame output buffering.

## Interface
- `DW`, 15: word MSB index; each word is signed [DW:0].
- `LW`, 8: lane width. (DW+1) % LW must be 0; BEATS = (DW+1)/LW.
- `clk`  input  1  the block's only clock; all logic is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  lane beat valid.
- `s_ready`  output  1  lane beat accepted when `s_valid && s_ready`.
- `s_data`  input  LW  lane beat.
- `s_last`  input  1  marks the final beat of a frame.
- `m_valid`  output  1  output frame valid.
- `m_ready`  input  1  consumer accepts the frame.
- `m_a1a`, `m_a2a`, `m_a3a`  output  signed [DW:0]  reassembled words.
- `frame_err`  output  1  one-cycle pulse on a framing error.

## Operation
- Frame = 3 words × BEATS beats. Word order a1a, a2a, a3a; within a word, beats are LSB-first. No sign extension or arithmetic; bits are placed verbatim.
- Beat counter runs 0..BEATS-1, word counter 0..2; both wrap to 0 after the final beat of a frame, or on an error.
- FSM states:
  - COLLECT: shift accepted beats into the assembly register.
    - If the final beat has `s_last`=1: copy to the output register, set `m_valid`.
    - If `s_last`=1 on any earlier beat: pulse `frame_err`, drop the partial frame, restart counters, and stay in COLLECT.
    - If the final beat has `s_last`=0: pulse `frame_err` and go to DISCARD.
  - DISCARD: accept and drop beats (`s_ready`=1). On a beat with `s_last`=1, return to COLLECT with counters at 0. No `frame_err` is raised while in DISCARD.
- Output register holds one frame.
  - Assembly of the next frame continues while `m_valid && !m_ready`.
  - `s_ready` deasserts only while the next frame's final beat is pending and the output register is still occupied.
- `m_a*` are stable while `m_valid && !m_ready`.
- Reset (any time, including mid-frame):
  - Partial frame discarded, counters 0, state COLLECT.
  - `m_valid`=0, `m_a1a`/`m_a2a`/`m_a3a`=0, `frame_err`=0.
  - `s_ready` reads 0 while `rst_n`=0.

## Timing
- Latency: `m_valid` rises on the cycle after the final beat is accepted.
- Throughput: one beat per cycle sustained when `m_ready`=1; frames are back-to-back with no bubble.
- Final beat accepted in the same cycle the consumer takes the held frame (`m_valid && m_ready`): the new frame loads and `m_valid` stays 1.
- `frame_err` rises on the cycle after the offending beat and lasts exactly one cycle.
- `s_ready` is combinational from state, counters, `m_valid` and `m_ready`. It does not depend on `s_valid`.

## Configuration
- `TRI_DESER_LAST_CHECK_EN` defined:
  - `s_last` is checked as above.
  - DISCARD state is present.
  - `frame_err` is live.
- `TRI_DESER_LAST_CHECK_EN` undefined:
  - `s_last` is ignored; frames are delimited purely by beat count.
  - DISCARD state is removed.
  - `frame_err` is tied to 0.

## Structure
- Package `tri_deser_pkg`: state enum (COLLECT, DISCARD), `NUM_WORDS`=3, and a function computing BEATS from DW/LW.
- Sub-module `tri_deser_out_reg`: the one-frame output holding register with its valid/ready logic. It exports an "occupied and not draining" flag, which the main FSM uses to gate `s_ready`.
- An elaboration-time check rejects configurations where (DW+1) % LW != 0.

## Test plan
Default parameters: DW=15, LW=8, so BEATS=2 and a frame is 6 beats. Macro defined unless noted.
- Basic frame: beats 34,12,CD,AB,00,80 with `s_last` on beat 6, `m_ready`=1 -> one cycle later `m_valid`=1 with `m_a1a`=16'h1234, `m_a2a`=16'hABCD (-21555), `m_a3a`=16'h8000 (-32768).
- Backpressure: two back-to-back frames with `m_ready`=0 -> first frame held stable; `s_ready`=0 at the second frame's beat 6 until `m_ready`=1. Then the second frame loads with no beat lost.
- Early last: `s_last` on beat 4 -> `frame_err` pulses once, no `m_valid`. A following good frame 01,00,02,00,03,00 yields words 1, 2, 3.
- Missing last: 6 beats with no `s_last`, then 3 junk beats with `s_last` on the third -> one `frame_err` pulse, no `m_valid`, next good frame decoded correctly.
- Reset mid-frame: `rst_n` low after 3 beats -> all outputs 0 and `s_ready`=0 during reset. The next full frame decodes correctly.
- Macro undefined: 6 beats with random `s_last` -> `m_valid` after beat 6 with correct words; `frame_err` never asserts.
